mem_port_arbiter: RTL and testbench

- Shares one external memory port between the instruction-fetch requester (I side) and the load/store requester (D side) of the pipelined CPU.
- Sits between the fetch/data-memory interface logic and the unified memory. The D side supplies byte enables and data already aligned to the word lane.
- Holds one transaction outstanding at a time. D has priority, with a starvation guard so I is still served.
- Each requester stalls until it sees its grant and, for reads, its response.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared encodings for the I/D memory port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

    // The memory sees word addresses only; the byte offset is carried by byteen.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module  : mem_arb_pick
// Brief   : Combinational I/D winner selection; D wins ties unless I is starved.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic starve,
    output logic grant_i,
    output logic grant_d
);

    always_comb begin
        grant_i = i_req & (~d_req | starve);
        grant_d = d_req & ~(i_req & starve);
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one memory port between fetch (I) and load/store (D),
//           one transaction outstanding, D priority with a starvation guard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_byteen,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      r_state;
    owner_t      r_owner;
    logic        r_mem_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_byteen;
    logic [31:0] r_wdata;
    logic [3:0]  r_streak;

    logic        w_starve;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_arb_open;
    logic        w_resp_hit;

    assign w_starve = (r_streak == c_STARVE_MAX);

    mem_arb_pick u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
        .starve  (w_starve),
        .grant_i (w_grant_i),
        .grant_d (w_grant_d)
    );

    // Grants and read returns are combinational, so they are masked during
    // reset to keep every output at zero while reset is held.
    assign w_arb_open = (r_state == IDLE) & ~reset;
    assign w_resp_hit = (r_state == RESP) & mem_rvalid & ~reset;

    assign i_gnt    = w_arb_open & w_grant_i;
    assign d_gnt    = w_arb_open & w_grant_d;
    assign i_rvalid = w_resp_hit & (r_owner == OWN_I);
    assign d_rvalid = w_resp_hit & (r_owner == OWN_D);
    assign i_rdata  = i_rvalid ? mem_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? mem_rdata : 32'h0;

    assign mem_req    = r_mem_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_byteen = r_byteen;
    assign mem_wdata  = r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_owner   <= OWN_I;
            r_mem_req <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_byteen  <= 4'h0;
            r_wdata   <= 32'h0;
            r_streak  <= 4'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= REQ;
                        r_mem_req <= 1'b1;
                        r_owner   <= OWN_D;
                        r_we      <= d_we;
                        r_addr    <= word_align(d_addr);
                        r_byteen  <= d_we ? d_byteen : BYTEEN_WORD;
                        r_wdata   <= d_we ? d_wdata  : 32'h0;
                        // Only D wins taken over a waiting I count toward starvation.
                        if (!i_req) begin
                            r_streak <= 4'h0;
                        end else if (!w_starve) begin
                            r_streak <= r_streak + 4'h1;
                        end
                    end else if (w_grant_i) begin
                        r_state   <= REQ;
                        r_mem_req <= 1'b1;
                        r_owner   <= OWN_I;
                        r_we      <= 1'b0;
                        r_addr    <= word_align(i_addr);
                        r_byteen  <= BYTEEN_WORD;
                        r_wdata   <= 32'h0;
                        r_streak  <= 4'h0;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        // Stores are posted: no response phase.
                        r_state   <= r_we ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Scoreboard bench with a transaction-level memory reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [3:0]  d_byteen = 4'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byteen(d_byteen), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [31:0] iexp_q[$];
    logic [31:0] dexp_q[$];
    logic [31:0] model_mem[16];
    logic [31:0] phys_mem[16];
    bit          gnt_log[$];
    bit          log_on = 0;
    int          phase = 0;       // 0 free, 1 command at memory, 2 awaiting read data
    int          waits_d = 0;     // D wins while I waited since I was last served
    bit          own_d = 0;
    bit          rst_sampled = 1;

    function automatic void apply_store(ref logic [31:0] m[16], input logic [31:0] a,
                                        input logic [3:0] be, input logic [31:0] wd);
        for (int b = 0; b < 4; b++)
            if (be[b]) m[a[5:2]][8*b +: 8] = wd[8*b +: 8];
    endfunction

    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("gnt_rvalid_in_reset", {28'h0, i_gnt, d_gnt, i_rvalid, d_rvalid}, 32'h0);
            check("rdata_in_reset", i_rdata | d_rdata, 32'h0);
            phase = 0; waits_d = 0;
            cmd_q.delete(); iexp_q.delete(); dexp_q.delete();
        end else begin
            bit egi, egd, eir, edr;
            int nphase;
            if (rst_sampled) begin
                check("rst_mem_req", {31'h0, mem_req}, 32'h0);
                check("rst_mem_we", {31'h0, mem_we}, 32'h0);
                check("rst_mem_addr", mem_addr, 32'h0);
                check("rst_mem_byteen", {28'h0, mem_byteen}, 32'h0);
                check("rst_mem_wdata", mem_wdata, 32'h0);
            end
            egi = 0; egd = 0;
            if (phase == 0) begin
                if (i_req && d_req) begin
                    if (waits_d >= LIM) egi = 1; else egd = 1;
                end else begin
                    egi = i_req; egd = d_req;
                end
            end
            check("i_gnt", {31'h0, i_gnt}, {31'h0, egi});
            check("d_gnt", {31'h0, d_gnt}, {31'h0, egd});
            if (log_on && (i_gnt || d_gnt)) gnt_log.push_back(d_gnt);

            nphase = phase;
            eir = 0; edr = 0;
            if (phase == 1) begin
                check("mem_req_busy", {31'h0, mem_req}, 32'h1);
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_queue_empty got=0 exp=1 t=%0t", $time);
                end else begin
                    check("mem_we", {31'h0, mem_we}, {31'h0, cmd_q[0].we});
                    check("mem_addr", mem_addr, cmd_q[0].addr);
                    check("mem_byteen", {28'h0, mem_byteen}, {28'h0, cmd_q[0].be});
                    check("mem_wdata", mem_wdata, cmd_q[0].wd);
                    if (mem_ready) begin
                        nphase = cmd_q[0].we ? 0 : 2;
                        void'(cmd_q.pop_front());
                    end
                end
            end else begin
                check("mem_req_idle", {31'h0, mem_req}, 32'h0);
                if (phase == 2 && mem_rvalid) begin
                    eir = !own_d; edr = own_d; nphase = 0;
                end
            end
            check("i_rvalid", {31'h0, i_rvalid}, {31'h0, eir});
            check("d_rvalid", {31'h0, d_rvalid}, {31'h0, edr});
            if (eir && iexp_q.size() > 0) check("i_rdata", i_rdata, iexp_q.pop_front());
            else check("i_rdata_zero", i_rdata, 32'h0);
            if (edr && dexp_q.size() > 0) check("d_rdata", d_rdata, dexp_q.pop_front());
            else check("d_rdata_zero", d_rdata, 32'h0);

            if (egi) begin
                cmd_q.push_back('{1'b0, {i_addr[31:2], 2'b00}, 4'hF, 32'h0});
                iexp_q.push_back(model_mem[i_addr[5:2]]);
                own_d = 0; waits_d = 0; nphase = 1;
            end else if (egd) begin
                if (d_we) begin
                    cmd_q.push_back('{1'b1, {d_addr[31:2], 2'b00}, d_byteen, d_wdata});
                    apply_store(model_mem, d_addr, d_byteen, d_wdata);
                end else begin
                    cmd_q.push_back('{1'b0, {d_addr[31:2], 2'b00}, 4'hF, 32'h0});
                    dexp_q.push_back(model_mem[d_addr[5:2]]);
                end
                waits_d = i_req ? waits_d + 1 : 0;
                own_d = 1; nphase = 1;
            end
            phase = nphase;
        end
    end

    // ---------------- memory responder ----------------
    int          mode = 0;        // 0 zero-wait, 1 random, 2 ready after 3 req cycles, 3 slow data
    bit          spur_en = 0;
    bit          rsp_pending = 0;
    int          rsp_delay = 0;
    logic [31:0] rsp_data = 32'h0;
    int          req_age = 0;

    initial forever begin
        @(negedge clk);
        if (mem_rvalid && rsp_pending && rsp_delay == 0) rsp_pending = 0;
        if (mem_req && mem_ready && !reset) begin
            if (mem_we) apply_store(phys_mem, mem_addr, mem_byteen, mem_wdata);
            else begin
                rsp_pending = 1;
                rsp_data = phys_mem[mem_addr[5:2]];
                rsp_delay = (mode == 0) ? 0 : (mode == 3) ? 3 : $urandom_range(0, 2);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        rst_sampled = reset;
        #1;
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        if (rsp_pending) begin
            if (rsp_delay == 0) begin mem_rvalid = 1'b1; mem_rdata = rsp_data; end
            else rsp_delay--;
        end else if (spur_en && $urandom_range(0, 5) == 0) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        end
        case (mode)
            1: mem_ready = 1'($urandom_range(0, 1));
            2: begin
                if (mem_req) req_age++; else req_age = 0;
                mem_ready = (req_age > 2);
            end
            default: mem_ready = 1'b1;
        endcase
    end

    // ---------------- requester drivers ----------------
    function automatic logic [31:0] rand_addr();
        return 32'h0000_3000 | ($urandom & 32'h3F);
    endfunction

    task automatic i_txn(input logic [31:0] a);
        int n = 0;
        i_req = 1'b1; i_addr = a;
        do begin @(negedge clk); n++; end while (!i_gnt && n < 300);
        if (!i_gnt) begin checks++; errors++; $display("FAIL i_gnt_timeout got=0 exp=1"); end
        @(posedge clk); #1;
        i_req = 1'b0; i_addr = $urandom;
    endtask

    task automatic d_txn(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        int n = 0;
        d_req = 1'b1; d_we = we; d_addr = a; d_byteen = be; d_wdata = wd;
        do begin @(negedge clk); n++; end while (!d_gnt && n < 300);
        if (!d_gnt) begin checks++; errors++; $display("FAIL d_gnt_timeout got=0 exp=1"); end
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_byteen = 4'($urandom); d_wdata = $urandom;
    endtask

    task automatic gap(input int g);
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
    endtask

    task automatic i_stream(input int n, input int maxgap);
        for (int k = 0; k < n; k++) begin
            gap($urandom_range(0, maxgap));
            i_txn(rand_addr());
        end
    endtask

    // kind: 0 mixed, 1 stores only, 2 loads only
    task automatic d_stream(input int n, input int maxgap, input int kind);
        for (int k = 0; k < n; k++) begin
            logic we;
            gap($urandom_range(0, maxgap));
            we = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : 1'($urandom);
            d_txn(we, rand_addr(), 4'($urandom), $urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            model_mem[k] = $urandom;
            phys_mem[k] = model_mem[k];
        end
        model_mem[1] = 32'h12345678;
        phys_mem[1] = 32'h12345678;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // single zero-wait fetch from an unaligned address
        i_txn(32'h0000_3006);
        gap(4);

        // store with the memory holding off acceptance for two cycles
        mode = 2;
        d_txn(1'b1, 32'h0000_0010, 4'b0100, 32'h00AB0000);
        gap(6);

        // continuous contention, D stores only
        mode = 0;
        log_on = 1;
        fork
            i_stream(4, 0);
            d_stream(16, 0, 1);
        join
        log_on = 0;
        gap(4);
        check("contention_log_len", 32'(gnt_log.size() >= 10), 32'h1);
        for (int k = 0; k < 10 && k < gnt_log.size(); k++)
            check($sformatf("grant_order_%0d", k), {31'h0, gnt_log[k]}, (k % 5 == 4) ? 32'h0 : 32'h1);

        // back-to-back D loads against zero-wait memory
        d_stream(6, 0, 2);
        gap(4);

        // reset while a D load is waiting for its data
        mode = 3;
        d_txn(1'b0, rand_addr(), 4'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        gap(8);

        // randomized mixed traffic with spurious responses
        mode = 1;
        spur_en = 1;
        fork
            i_stream(40, 3);
            d_stream(40, 3, 0);
        join
        mode = 0;
        spur_en = 0;
        gap(10);
        check("drain_empty", 32'(cmd_q.size() + iexp_q.size() + dexp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
